enemy_spawn_sched: RTL and testbench

//  Spawn scheduler for the three enemy instances under enemy_top (enemy1_slow, enemy2, enemy3).

---
 rtl/enemy_spawn_sched_pkg.sv | 34 +++
 rtl/enemy_spawn_sched_vsync_tick.sv | 28 ++
 rtl/enemy_spawn_sched.sv | 153 +++++++++++++++
 tb/tb_enemy_spawn_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_spawn_sched_pkg.sv
// Shared types and helpers for the enemy spawn scheduler: widths, FSM encoding and
// the rotate-to-free type selector.
package enemy_spawn_sched_pkg;

    localparam int RAND_WIDTH  = 16;
    localparam int H_DISP_LEN  = 10;
    localparam int ENEMY_TYPES = 3;

    typedef enum logic [1:0] {
        SPAWN_IDLE = 2'd0,
        SPAWN_WAIT = 2'd1,
        SPAWN_PICK = 2'd2,
        SPAWN_REQ  = 2'd3
    } spawn_state_t;

    // One-hot of the first free type starting at 'first' and walking upward modulo
    // ENEMY_TYPES; all zeros when every type is already on screen.
    function automatic logic [ENEMY_TYPES-1:0] rotate_to_free(
        input logic [1:0]             first,
        input logic [ENEMY_TYPES-1:0] alive
    );
        logic [ENEMY_TYPES-1:0] pick;
        logic [1:0]             k;
        pick = '0;
        for (int i = ENEMY_TYPES - 1; i >= 0; i--) begin
            k = 2'((int'(first) + i) % ENEMY_TYPES);
            if (!alive[k]) begin
                pick = ENEMY_TYPES'(1) << k;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/enemy_spawn_sched_vsync_tick.sv
// Brings the asynchronous vsync into the run clock domain and emits a one-cycle
// frame tick on its rising edge; reusable by any frame-driven block.
module enemy_spawn_sched_vsync_tick (
    input  logic clk_run,
    input  logic rst,
    input  logic v_sync_i,
    output logic frame_tick_o
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clk_run or negedge rst) begin
        if (!rst) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            prev_reg     <= 1'b0;
            frame_tick_o <= 1'b0;
        end else begin
            sync1_reg    <= v_sync_i;
            sync2_reg    <= sync1_reg;
            prev_reg     <= sync2_reg;
            frame_tick_o <= sync2_reg & ~prev_reg;
        end
    end

endmodule

// File: rtl/enemy_spawn_sched.sv
// Spawn scheduler for the three enemy types: frame-counted attempts, weighted type draw
// with rotate-to-free, held one-hot request with X position, and a spawn-driven ramp.
module enemy_spawn_sched
    import enemy_spawn_sched_pkg::*;
#(
    parameter int INTERVAL_INIT = 60,
    parameter int INTERVAL_MIN  = 15,
    parameter int INTERVAL_DEC  = 5,
    parameter int RAMP_STEP     = 8,
    parameter int W1_TH         = 128,
    parameter int W2_TH         = 208,
    parameter int ACK_TIMEOUT   = 4,
    parameter int X_MAX         = 440
) (
    input  logic                   clk_run,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic [RAND_WIDTH-1:0]  rand_i,
    input  logic                   v_sync_i,
    input  logic [ENEMY_TYPES-1:0] alive_i,
    input  logic [ENEMY_TYPES-1:0] spawn_ack_i,
    output logic [ENEMY_TYPES-1:0] spawn_req_o,
    output logic [H_DISP_LEN-1:0]  spawn_x_o,
    output logic [3:0]             level_o
);

    if (INTERVAL_INIT > 255 || INTERVAL_MIN < 1 || INTERVAL_INIT < INTERVAL_MIN ||
        INTERVAL_DEC > 255 || RAMP_STEP < 1 || RAMP_STEP > 255 ||
        ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255 || W1_TH > W2_TH || W2_TH > 256 ||
        X_MAX + 1 >= 2 ** H_DISP_LEN || RAND_WIDTH <= H_DISP_LEN || RAND_WIDTH < 8) begin : g_param_check
        $error("enemy_spawn_sched: parameter does not fit the 8-bit counters or X width");
    end

    localparam logic [7:0] INTERVAL_INIT_L = 8'(INTERVAL_INIT);
    localparam logic [7:0] INTERVAL_MIN_L  = 8'(INTERVAL_MIN);
    localparam logic [7:0] INTERVAL_DEC_L  = 8'(INTERVAL_DEC);
    localparam logic [8:0] FLOOR_EDGE      = 9'(INTERVAL_MIN + INTERVAL_DEC);
    localparam logic [7:0] RAMP_STEP_L     = 8'(RAMP_STEP);
    localparam logic [7:0] ACK_TIMEOUT_L   = 8'(ACK_TIMEOUT);
    localparam logic [8:0] W1_L            = 9'(W1_TH);
    localparam logic [8:0] W2_L            = 9'(W2_TH);
    localparam logic [H_DISP_LEN-1:0] X_MAX_L  = H_DISP_LEN'(X_MAX);
    localparam logic [H_DISP_LEN-1:0] X_WRAP_L = H_DISP_LEN'(X_MAX + 1);

    spawn_state_t           state_reg;
    logic [7:0]             interval_reg;
    logic [7:0]             frame_cnt_reg;
    logic [7:0]             spawn_cnt_reg;
    logic [7:0]             timeout_cnt_reg;

    logic                   frame_tick;
    logic [1:0]             draw_t;
    logic [ENEMY_TYPES-1:0] free_onehot;
    logic [H_DISP_LEN-1:0]  raw_x;
    logic [H_DISP_LEN-1:0]  wrap_x;
    logic [H_DISP_LEN-1:0]  clamp_x;
    logic [7:0]             interval_dec;
    logic                   ack_hit;
    logic                   unused_rand;

    enemy_spawn_sched_vsync_tick u_vsync_tick (
        .clk_run      (clk_run),
        .rst          (rst),
        .v_sync_i     (v_sync_i),
        .frame_tick_o (frame_tick)
    );

    assign draw_t = ({1'b0, rand_i[7:0]} < W1_L) ? 2'd0 :
                    ({1'b0, rand_i[7:0]} < W2_L) ? 2'd1 : 2'd2;
    assign free_onehot = rotate_to_free(draw_t, alive_i);

    // Out-of-range X wraps once past the right edge; anything still too large pins to X_MAX.
    assign raw_x   = rand_i[H_DISP_LEN-1:0];
    assign wrap_x  = raw_x - X_WRAP_L;
    assign clamp_x = (raw_x <= X_MAX_L) ? raw_x : ((wrap_x > X_MAX_L) ? X_MAX_L : wrap_x);

    assign interval_dec = ({1'b0, interval_reg} >= FLOOR_EDGE) ? (interval_reg - INTERVAL_DEC_L)
                                                               : INTERVAL_MIN_L;
    // The request is one-hot, so masking with it ignores acks from other types.
    assign ack_hit     = |(spawn_ack_i & spawn_req_o);
    assign unused_rand = ^rand_i[RAND_WIDTH-1:H_DISP_LEN];

    always_ff @(posedge clk_run or negedge rst) begin
        if (!rst) begin
            state_reg       <= SPAWN_IDLE;
            interval_reg    <= INTERVAL_INIT_L;
            frame_cnt_reg   <= '0;
            spawn_cnt_reg   <= '0;
            timeout_cnt_reg <= '0;
            spawn_req_o     <= '0;
            spawn_x_o       <= '0;
            level_o         <= '0;
        end else if (!en_i) begin
            // Pause: drop any request but keep the difficulty state.
            state_reg       <= SPAWN_IDLE;
            frame_cnt_reg   <= '0;
            timeout_cnt_reg <= '0;
            spawn_req_o     <= '0;
            spawn_x_o       <= '0;
        end else begin
            case (state_reg)
                SPAWN_IDLE: begin
                    state_reg     <= SPAWN_WAIT;
                    frame_cnt_reg <= '0;
                end
                SPAWN_WAIT: begin
                    if (frame_tick) begin
                        if (frame_cnt_reg + 8'd1 == interval_reg) begin
                            state_reg     <= SPAWN_PICK;
                            frame_cnt_reg <= '0;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        end
                    end
                end
                SPAWN_PICK: begin
                    if (free_onehot == '0) begin
                        state_reg <= SPAWN_WAIT;
                    end else begin
                        state_reg       <= SPAWN_REQ;
                        spawn_req_o     <= free_onehot;
                        spawn_x_o       <= clamp_x;
                        timeout_cnt_reg <= '0;
                    end
                end
                SPAWN_REQ: begin
                    if (ack_hit) begin
                        state_reg   <= SPAWN_WAIT;
                        spawn_req_o <= '0;
                        if (spawn_cnt_reg + 8'd1 == RAMP_STEP_L) begin
                            spawn_cnt_reg <= '0;
                            interval_reg  <= interval_dec;
                            if (level_o != 4'hF) begin
                                level_o <= level_o + 4'd1;
                            end
                        end else begin
                            spawn_cnt_reg <= spawn_cnt_reg + 8'd1;
                        end
                    end else if (frame_tick) begin
                        if (timeout_cnt_reg + 8'd1 == ACK_TIMEOUT_L) begin
                            state_reg   <= SPAWN_WAIT;
                            spawn_req_o <= '0;
                        end else begin
                            timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
                        end
                    end
                end
                default: state_reg <= SPAWN_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_spawn_sched.sv
// Cycle-stepped bench: vsync frames at a 6-cycle period, a scoreboard of expected
// requests checked when spawn_req_o rises, and a small difficulty model.
module tb_enemy_spawn_sched;
    import enemy_spawn_sched_pkg::*;

    logic                   clk_run = 1'b0;
    logic                   rst;
    logic                   en_i;
    logic [RAND_WIDTH-1:0]  rand_i;
    logic                   v_sync_i;
    logic [ENEMY_TYPES-1:0] alive_i;
    logic [ENEMY_TYPES-1:0] spawn_ack_i;
    logic [ENEMY_TYPES-1:0] spawn_req_o;
    logic [H_DISP_LEN-1:0]  spawn_x_o;
    logic [3:0]             level_o;

    always #5 clk_run = ~clk_run;

    enemy_spawn_sched dut (
        .clk_run     (clk_run),
        .rst         (rst),
        .en_i        (en_i),
        .rand_i      (rand_i),
        .v_sync_i    (v_sync_i),
        .alive_i     (alive_i),
        .spawn_ack_i (spawn_ack_i),
        .spawn_req_o (spawn_req_o),
        .spawn_x_o   (spawn_x_o),
        .level_o     (level_o)
    );

    typedef struct { logic [2:0] req; int x; int level; int gap; } exp_t;
    typedef struct { int rnd; logic [2:0] alive; logic [2:0] req; int x; } vec_t;

    exp_t       sb[$];
    vec_t       vecs[13];
    int         passed = 0, total = 0;
    int         cyc = 0, rises = 0, last_rise_edge = -100, anchor = 0, phase = 0;
    bit         frames_on = 1'b0;
    int         ack_mode = 0;
    logic [2:0] prev_req = 3'b000;
    logic [2:0] held_req = 3'b000;
    int         held_x = 0;
    bit         rise_flag = 1'b0, fall_flag = 1'b0;
    int         rise_cyc = 0, fall_cyc = 0, rise_rises = 0, fall_rises = 0;
    int         m_interval = 60, m_level = 0, m_cnt = 0, m_spawns = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic monitor();
        exp_t e;
        if (prev_req == 3'b000 && spawn_req_o != 3'b000) begin
            rise_flag  = 1'b1;
            rise_cyc   = cyc;
            rise_rises = rises;
            if (sb.size() == 0) begin
                check("unexpected_req", 32'(spawn_req_o), 32'd0);
            end else begin
                e = sb.pop_front();
                check("req_onehot", 32'(spawn_req_o), 32'(e.req));
                check("req_x", 32'(spawn_x_o), e.x);
                check("req_level", 32'(level_o), e.level);
                check("frames_to_req", rises - anchor, e.gap);
                // 2 sync flops + edge register + PICK after the vsync edge
                check("vsync_to_req_cycles", cyc - last_rise_edge, 32'd4);
                held_req = e.req;
                held_x   = e.x;
            end
            $display("req  cyc=%0d req=%b x=%0d level=%0d", cyc, spawn_req_o, spawn_x_o, level_o);
        end else if (prev_req != 3'b000 && spawn_req_o != 3'b000) begin
            check("req_hold", 32'({spawn_req_o, spawn_x_o}), 32'({held_req, H_DISP_LEN'(held_x)}));
        end else if (prev_req != 3'b000 && spawn_req_o == 3'b000) begin
            fall_flag  = 1'b1;
            fall_cyc   = cyc;
            fall_rises = rises;
            anchor     = rises;
        end
        prev_req = spawn_req_o;
    endtask

    task automatic tick_cycle();
        if (frames_on) begin
            v_sync_i = (phase < 3);
            if (phase == 0) begin
                rises++;
                last_rise_edge = cyc + 1;
            end
            phase = (phase + 1) % 6;
        end else begin
            v_sync_i = 1'b0;
        end
        case (ack_mode)
            1: spawn_ack_i = spawn_req_o;
            2: spawn_ack_i = (spawn_req_o != 3'b000) ? ~spawn_req_o : 3'b000;
            3: spawn_ack_i = (spawn_req_o != 3'b000 && rises - rise_rises == 4 &&
                              cyc == last_rise_edge + 2) ? spawn_req_o : 3'b000;
            default: spawn_ack_i = 3'b000;
        endcase
        @(posedge clk_run);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic expect_req(input logic [2:0] req, input int x, input int gap);
        exp_t e;
        e.req = req; e.x = x; e.level = m_level; e.gap = gap;
        sb.push_back(e);
        rise_flag = 1'b0;
        fall_flag = 1'b0;
    endtask

    task automatic wait_rise(input int budget);
        int n = 0;
        while (!rise_flag && n < budget) begin
            tick_cycle();
            n++;
        end
        check("req_seen", 32'(rise_flag), 32'd1);
        if (!rise_flag) sb.delete();
        rise_flag = 1'b0;
    endtask

    task automatic wait_fall(input int budget);
        int n = 0;
        while (!fall_flag && n < budget) begin
            tick_cycle();
            n++;
        end
        check("req_release_seen", 32'(fall_flag), 32'd1);
        fall_flag = 1'b0;
    endtask

    task automatic model_spawn();
        m_spawns++;
        m_cnt++;
        if (m_cnt == 8) begin
            m_cnt      = 0;
            m_interval = (m_interval - 5 < 15) ? 15 : m_interval - 5;
            if (m_level < 15) m_level++;
        end
        check("level_after_spawn", 32'(level_o), m_level);
    endtask

    task automatic acked_spawn(input logic [2:0] req, input int x);
        expect_req(req, x, m_interval);
        wait_rise(6 * (m_interval + 8) + 40);
        wait_fall(20);
        check("ack_clears_next_cycle", fall_cyc - rise_cyc, 32'd1);
        model_spawn();
    endtask

    task automatic start_frames();
        anchor    = rises;
        phase     = 0;
        frames_on = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{10,   3'b000, 3'b001, 10};
        vecs[1]  = '{150,  3'b010, 3'b100, 150};
        vecs[2]  = '{150,  3'b000, 3'b010, 150};
        vecs[3]  = '{250,  3'b100, 3'b001, 250};
        vecs[4]  = '{100,  3'b011, 3'b100, 100};
        vecs[5]  = '{500,  3'b000, 3'b100, 59};
        vecs[6]  = '{440,  3'b000, 3'b010, 440};
        vecs[7]  = '{1023, 3'b000, 3'b100, 440};
        vecs[8]  = '{441,  3'b000, 3'b010, 0};
        vecs[9]  = '{127,  3'b000, 3'b001, 127};
        vecs[10] = '{128,  3'b000, 3'b010, 128};
        vecs[11] = '{208,  3'b000, 3'b100, 208};
        vecs[12] = '{207,  3'b010, 3'b100, 207};

        rst = 1'b0; en_i = 1'b0; rand_i = '0; v_sync_i = 1'b0;
        alive_i = 3'b000; spawn_ack_i = 3'b000;
        repeat (3) tick_cycle();
        check("reset_req", 32'(spawn_req_o), 32'd0);
        check("reset_x", 32'(spawn_x_o), 32'd0);
        check("reset_level", 32'(level_o), 32'd0);
        rst = 1'b1;
        en_i = 1'b1;
        repeat (2) tick_cycle();
        start_frames();

        // Type draw, rotate-to-free and X clamp vectors, each acked immediately.
        ack_mode = 1;
        for (int i = 0; i < 13; i++) begin
            rand_i  = RAND_WIDTH'(vecs[i].rnd);
            alive_i = vecs[i].alive;
            acked_spawn(vecs[i].req, vecs[i].x);
        end

        // All types alive: the attempt is skipped and the next one comes an interval later.
        rand_i  = RAND_WIDTH'(10);
        alive_i = 3'b111;
        expect_req(3'b001, 10, 2 * m_interval);
        for (int n = 0; n < 6 * (m_interval + 4) && rises - anchor < m_interval + 1; n++) tick_cycle();
        alive_i = 3'b000;
        wait_rise(6 * (m_interval + 8) + 40);
        wait_fall(20);
        model_spawn();

        // Only wrong-type acks: request times out after 4 frames and is not counted.
        ack_mode = 2;
        expect_req(3'b001, 10, m_interval);
        wait_rise(6 * (m_interval + 8) + 40);
        wait_fall(80);
        check("timeout_hold_frames", fall_rises - rise_rises, 32'd4);
        check("timeout_level", 32'(level_o), m_level);

        // Ack lands on the same cycle as the 4th frame tick: the ack wins and counts.
        ack_mode = 3;
        expect_req(3'b001, 10, m_interval);
        wait_rise(6 * (m_interval + 8) + 40);
        wait_fall(80);
        check("ack_vs_tick_hold_frames", fall_rises - rise_rises, 32'd4);
        model_spawn();

        // Difficulty ramp through the interval floor and level saturation.
        ack_mode = 1;
        while (m_spawns < 130) acked_spawn(3'b001, 10);
        check("level_saturated", 32'(level_o), 32'd15);

        // Pause mid-request: request dropped, level kept, counting resumes from zero.
        ack_mode = 0;
        expect_req(3'b001, 10, m_interval);
        wait_rise(6 * (m_interval + 8) + 40);
        en_i = 1'b0;
        tick_cycle();
        check("pause_req", 32'(spawn_req_o), 32'd0);
        check("pause_level", 32'(level_o), m_level);
        frames_on = 1'b0;
        repeat (8) tick_cycle();
        en_i = 1'b1;
        ack_mode = 1;
        repeat (2) tick_cycle();
        start_frames();
        acked_spawn(3'b001, 10);

        // Asynchronous reset mid-request clears outputs at once and restores the interval.
        ack_mode = 0;
        expect_req(3'b001, 10, m_interval);
        wait_rise(6 * (m_interval + 8) + 40);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_req", 32'(spawn_req_o), 32'd0);
        check("async_rst_x", 32'(spawn_x_o), 32'd0);
        check("async_rst_level", 32'(level_o), 32'd0);
        frames_on = 1'b0;
        repeat (8) tick_cycle();
        m_interval = 60; m_level = 0; m_cnt = 0;
        rst = 1'b1;
        ack_mode = 1;
        repeat (2) tick_cycle();
        start_frames();
        acked_spawn(3'b001, 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
